// File: rtl/pll_reset_seq.sv
// PLL bring-up / system-reset sequencer clocked from the free-running HSOSC.
// Lock, held stable long enough, releases system reset; it never releases the PLL's own reset.
module pll_reset_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               locked,
  output logic                               pll_rst_n,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int RC_W    = $clog2(MAX_RETRIES + 1);
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  MAX_RC       = RC_W'(MAX_RETRIES);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  // The reset hold must outlast the synchronizer so a stale lock is flushed.
  generate
    if (PLL_RST_CYCLES < SYNC_STAGES + 2) begin : g_param_chk
      $error("pll_reset_seq: PLL_RST_CYCLES must be >= SYNC_STAGES+2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RC_W-1:0]        retry_q, retry_d;
  logic                   pll_rst_n_q, pll_rst_n_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = SYNC_STAGES'({sync_q, locked});
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == MAX_RC) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry_q + RC_W'(1);
            state_d = S_PLL_RST;
          end
        end
      end
      S_STABLE: begin
        // A drop on the terminal-count edge still wins over entering RUN.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lock_lost_d = 1'b1;
          state_d     = S_PLL_RST;
        end
      end
      S_FAULT: ;
      default: state_d = S_PLL_RST;
    endcase

    // RUN and FAULT have no terminal count, so the counter parks there.
    if (state_d != state_q)                         cnt_d = '0;
    else if (state_q == S_RUN || state_q == S_FAULT) cnt_d = cnt_q;
    else                                            cnt_d = cnt_q + CNT_W'(1);

    pll_rst_n_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = fault_q || (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_n_q <= pll_rst_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst_n   = pll_rst_n_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed bring-up scenarios plus random lock activity,
// all compared against a timestamp/delay-line reference model.
module tb_pll_reset_seq;
  localparam int PRC = 4, LSC = 8, LTC = 32, MR = 2, SS = 2;
  localparam int RCW = $clog2(MR + 1);

  logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0;
  logic pll_rst_n, sys_rst_n, ready, fault, lock_lost;
  logic [RCW-1:0] retry_count;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES(MR), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .pll_rst_n(pll_rst_n),
    .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault), .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  typedef enum int {P_RST, P_WAIT, P_STABLE, P_RUN, P_FAULT} phase_e;
  phase_e m_ph;
  int     m_t0, m_edge, m_retry;
  bit     m_fault, m_lost;
  bit     dq[$];
  int     checks = 0, errors = 0, ecount = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_ph = P_RST; m_t0 = 0; m_edge = 0; m_retry = 0; m_fault = 0; m_lost = 0;
    dq.delete();
    for (int i = 0; i < SS; i++) dq.push_back(1'b0);
  endfunction

  function automatic void m_go(phase_e p);
    m_ph = p;
    m_t0 = m_edge + 1;
  endfunction

  // One clock edge: lock seen by the sequencer is the sample taken SS edges earlier.
  function automatic void m_step(bit lk);
    bit ls;
    int el;
    ls = dq.pop_front();
    dq.push_back(lk);
    el = m_edge - m_t0;
    case (m_ph)
      P_RST:    if (el == PRC - 1) m_go(P_WAIT);
      P_WAIT: begin
        if (ls) m_go(P_STABLE);
        else if (el == LTC - 1) begin
          if (m_retry == MR) begin m_fault = 1; m_go(P_FAULT); end
          else begin m_retry++; m_go(P_RST); end
        end
      end
      P_STABLE: begin
        if (!ls) m_go(P_WAIT);
        else if (el == LSC - 1) begin m_retry = 0; m_go(P_RUN); end
      end
      P_RUN:    if (!ls) begin m_lost = 1; m_go(P_RST); end
      default: ;
    endcase
    m_edge++;
  endfunction

  function automatic logic [31:0] m_outs();
    bit p, r;
    logic [RCW-1:0] rc;
    p  = (m_ph == P_WAIT) || (m_ph == P_STABLE) || (m_ph == P_RUN);
    r  = (m_ph == P_RUN);
    rc = RCW'(m_retry);
    return 32'({p, r, r, m_fault, m_lost, rc});
  endfunction

  function automatic logic [31:0] dut_outs();
    return 32'({pll_rst_n, sys_rst_n, ready, fault, lock_lost, retry_count});
  endfunction

  task automatic step(input bit lk);
    locked = lk;
    @(posedge clk);
    m_step(lk);
    ecount++;
    #1 chk("outs", dut_outs(), m_outs());
  endtask

  // Assert rst_n between edges and check outputs clear with no clock edge.
  task automatic do_reset(input bit lk);
    @(negedge clk);
    locked = lk;
    rst_n  = 1'b0;
    #1;
    m_reset();
    chk("rst_async", dut_outs(), 32'd0);
    #2 rst_n = 1'b1;
    ecount = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_p, rise_s, fall, d, fe, run;
    bit lk;

    #1 chk("rst_init", dut_outs(), 32'd0);

    // Clean bring-up
    do_reset(1);
    rise_p = 0; rise_s = 0;
    repeat (20) begin
      step(1);
      if (pll_rst_n && rise_p == 0) rise_p = ecount;
      if (sys_rst_n && rise_s == 0) rise_s = ecount;
    end
    chk("pll_rise", rise_p, 4);
    chk("sys_rise", rise_s, 13);
    chk("ready_run", ready, 1);
    chk("retry_clean", retry_count, 0);
    chk("fault_clean", fault, 0);

    // Lock glitch during STABLE
    do_reset(1);
    rise_s = 0;
    for (int i = 1; i <= 40; i++) begin
      step(i == 9 ? 1'b0 : 1'b1);
      if (sys_rst_n && rise_s == 0) rise_s = ecount;
    end
    chk("glitch_sys_rise", rise_s, 20);
    chk("glitch_retry", retry_count, 0);

    // Lock loss in RUN, then re-lock
    d = ecount + 1; fall = 0;
    for (int i = 0; i < 10; i++) begin
      step(i < 3 ? 1'b0 : 1'b1);
      if (!sys_rst_n && fall == 0) fall = ecount;
    end
    chk("lost_edge", fall, d + 2);
    chk("lost_flag", lock_lost, 1);
    repeat (30) step(1);
    chk("relock_ready", ready, 1);
    chk("relock_lost_sticky", lock_lost, 1);

    // Timeout / retry to FAULT
    do_reset(0);
    fe = 0;
    for (int i = 1; i <= 120; i++) begin
      step(0);
      if (ecount == 36) chk("retry_1", retry_count, 1);
      if (ecount == 39) chk("retry_pll_low", pll_rst_n, 0);
      if (ecount == 40) chk("retry_pll_high", pll_rst_n, 1);
      if (ecount == 72) chk("retry_2", retry_count, 2);
      if (fault && fe == 0) fe = ecount;
    end
    chk("fault_edge", fe, 108);
    chk("fault_pll", pll_rst_n, 0);
    chk("fault_held", fault, 1);

    // Reset out of FAULT, then retry-then-success
    do_reset(0);
    repeat (40) step(0);
    repeat (40) step(1);
    chk("retry_ok_ready", ready, 1);
    chk("retry_ok_count", retry_count, 0);
    chk("retry_ok_fault", fault, 0);

    // Reset mid-STABLE; bring-up restarts from PLL_RST
    do_reset(1);
    repeat (8) step(1);
    chk("stable_pll", pll_rst_n, 1);
    do_reset(1);
    repeat (12) step(1);
    chk("restart_sys_pre", sys_rst_n, 0);
    step(1);
    chk("restart_sys", sys_rst_n, 1);

    // Random lock activity with occasional resets
    do_reset(1);
    repeat (150) begin
      run = $urandom_range(1, 40);
      lk  = ($urandom_range(0, 3) != 0);
      repeat (run) step(lk);
      if ($urandom_range(0, 19) == 0) do_reset(lk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

PLL bring-up and system-reset sequencer that sits directly around the pixel-clock PLL. It drives the PLL's active-low reset from the free-running HSOSC reference clock and watches the PLL lock output. It requires lock to be continuously stable before releasing system reset, retries the PLL on lock timeout, and reports a sticky fault when retries are exhausted. It implements the rule that lock releases system reset, never the PLL's own reset.

## Interface
Parameters:
- PLL_RST_CYCLES, 16: cycles the PLL is held in reset per attempt; must be ≥ SYNC_STAGES+2 (elaboration-time check).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before system reset is released.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRIES, 3: number of retries allowed after the first attempt before FAULT.
- SYNC_STAGES, 2: flop depth of the lock synchronizer.

Ports:
- clk  in  1  free-running HSOSC reference clock; never the PLL output.
- rst_n  in  1  asynchronous, active-low reset.
- locked  in  1  raw PLL lock; asynchronous to clk; synchronized internally to lock_s.
- pll_rst_n  out  1  PLL reset, active low.
- sys_rst_n  out  1  system reset, active low. Asserts asynchronously with rst_n and deasserts synchronously to clk.
- ready  out  1  high only in RUN.
- fault  out  1  sticky; retries exhausted.
- lock_lost  out  1  sticky; lock dropped while in RUN.
- retry_count  out  $clog2(MAX_RETRIES+1)  retries consumed in the current bring-up.

## Operation
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT. Reset state is PLL_RST with its counter at 0.
- One shared cycle counter, cleared on every state transition.
- **PLL_RST:** pll_rst_n=0, sys_rst_n=0. Transitions to WAIT_LOCK on the edge where counter == PLL_RST_CYCLES-1.
- **WAIT_LOCK:** pll_rst_n=1.
  - lock_s=1: go to STABLE.
  - counter == LOCK_TIMEOUT_CYCLES-1 with lock_s=0: if retry_count == MAX_RETRIES, go to FAULT; otherwise increment retry_count and go to PLL_RST.
- **STABLE:** pll_rst_n=1.
  - lock_s=0: go to WAIT_LOCK; the timeout restarts from 0 and retry_count is unchanged.
  - lock_s=1 with counter == LOCK_STABLE_CYCLES-1: go to RUN.
- **RUN:** sys_rst_n=1, ready=1, retry_count cleared to 0 on entry.
  - lock_s=0: set lock_lost and go to PLL_RST; sys_rst_n=0 on that same edge.
- **FAULT:** pll_rst_n=0, sys_rst_n=0, fault=1. Terminal; only rst_n exits.
- Counter width is sized for the maximum of all three cycle parameters. The counter never wraps, because every terminal count forces a transition.

## Timing
- Reset values:
  - pll_rst_n=0, sys_rst_n=0, ready=0, fault=0, lock_lost=0, retry_count=0.
  - Lock synchronizer flops = 0.
- All outputs are registered and updated on the same edge as the state transition. No output glitches are permitted.
- Lock latency: a change on locked reaches lock_s after SYNC_STAGES edges.
- Minimum bring-up latency (lock_s already 1 at PLL release): sys_rst_n rises PLL_RST_CYCLES + 1 + LOCK_STABLE_CYCLES edges after the first edge with rst_n high.
- Stale lock: because PLL_RST_CYCLES ≥ SYNC_STAGES+2, lock from a previous attempt is flushed before WAIT_LOCK samples it.
- rst_n assertion mid-operation: all outputs go to their reset values immediately (asynchronous), including the sticky fault and lock_lost flags.
- Lock dropping on the exact edge where STABLE would enter RUN: the drop wins, and the FSM goes to WAIT_LOCK.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, SYNC_STAGES=2.

- **Clean bring-up:** locked held 1; release rst_n.
  - pll_rst_n rises at edge 4; sys_rst_n and ready rise at edge 13.
  - retry_count=0; fault=0.
- **Lock glitch during STABLE:** locked pulses 0 for 1 cycle, 3 cycles into STABLE.
  - FSM returns to WAIT_LOCK, then needs a fresh 8 consecutive lock_s cycles.
  - sys_rst_n rise is delayed accordingly; retry_count stays 0.
- **Timeout/retry to FAULT:** locked held 0.
  - retry_count steps 1 then 2; pll_rst_n pulses low for 4 cycles per retry.
  - fault=1 and pll_rst_n=0 at edge 108; both held until rst_n.
- **Lock loss in RUN:** after ready=1, drop locked.
  - sys_rst_n=0 and lock_lost=1 SYNC_STAGES+1 edges later.
  - Re-lock returns the FSM to RUN with lock_lost still 1.
- **Retry then success:** locked=0 through the first timeout, then locked=1.
  - RUN is reached with retry_count cleared to 0; fault=0.
- **Asynchronous reset mid-STABLE and in FAULT:** assert rst_n.
  - All outputs reach reset values without waiting for a clk edge.
  - Bring-up restarts from PLL_RST.
